// File: rtl/core_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32I control sequencer:
// opcodes, funct3, ALU ops, datapath selects and FSM state.
package core_ctrl_fsm_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

  localparam logic [2:0] FUNC3_ADD  = 3'b000;
  localparam logic [2:0] FUNC3_SLL  = 3'b001;
  localparam logic [2:0] FUNC3_SLT  = 3'b010;
  localparam logic [2:0] FUNC3_SLTU = 3'b011;
  localparam logic [2:0] FUNC3_XOR  = 3'b100;
  localparam logic [2:0] FUNC3_SR   = 3'b101;
  localparam logic [2:0] FUNC3_OR   = 3'b110;
  localparam logic [2:0] FUNC3_AND  = 3'b111;

  localparam logic [2:0] FUNC3_BEQ  = 3'b000;
  localparam logic [2:0] FUNC3_BNE  = 3'b001;
  localparam logic [2:0] FUNC3_BLT  = 3'b100;
  localparam logic [2:0] FUNC3_BGE  = 3'b101;
  localparam logic [2:0] FUNC3_BLTU = 3'b110;
  localparam logic [2:0] FUNC3_BGEU = 3'b111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic CTL_PC_PLUS4  = 1'b0;
  localparam logic CTL_PC_IMM    = 1'b1;
  localparam logic CTL_ALU_A_RS1 = 1'b0;
  localparam logic CTL_ALU_A_PC  = 1'b1;
  localparam logic CTL_ALU_B_RS2 = 1'b0;
  localparam logic CTL_ALU_B_IMM = 1'b1;
  localparam logic CTL_WB_ALU    = 1'b0;
  localparam logic CTL_WB_MEM    = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } state_t;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_OP,
    CLS_OPIMM,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH
  } cls_t;

  // Branch funct3 010/011 are reserved and fall into CLS_NONE.
  function automatic cls_t classify(
    input logic [6:0] opcode,
    input logic [2:0] funct3
  );
    cls_t c;
    c = CLS_NONE;
    case (opcode)
      OPCODE_OP:     c = CLS_OP;
      OPCODE_OP_IMM: c = CLS_OPIMM;
      OPCODE_LOAD:   c = CLS_LOAD;
      OPCODE_STORE:  c = CLS_STORE;
      OPCODE_BRANCH: begin
        if (funct3[2:1] != 2'b01)
          c = CLS_BRANCH;
      end
      default:       c = CLS_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/core_ctrl_fsm_alu_dec.sv
// ALU op decode from latched instruction class and funct fields,
// plus the branch-taken polarity (1 = taken when result non-zero).
module ctrl_alu_dec
  import core_ctrl_fsm_pkg::*;
(
  input  cls_t       cls,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] alu_op,
  output logic       br_inv
);

  logic alt;
  logic is_alu;
  logic is_br;
  logic f7_unused;

  assign alt       = funct7[5];
  assign is_alu    = (cls == CLS_OP) || (cls == CLS_OPIMM);
  assign is_br     = (cls == CLS_BRANCH);
  assign f7_unused = ^{funct7[6], funct7[4:0]};

  // Map class/funct to ALU op; immediates only honour alt on shifts.
  always_comb begin
    alu_op = ALU_ADD;
    br_inv = 1'b0;
    unique case (1'b1)
      is_alu: begin
        case (funct3)
          FUNC3_ADD:  alu_op = (cls == CLS_OP && alt)
                               ? ALU_SUB : ALU_ADD;
          FUNC3_SLL:  alu_op = ALU_SLL;
          FUNC3_SLT:  alu_op = ALU_SLT;
          FUNC3_SLTU: alu_op = ALU_SLTU;
          FUNC3_XOR:  alu_op = ALU_XOR;
          FUNC3_SR:   alu_op = alt ? ALU_SRA : ALU_SRL;
          FUNC3_OR:   alu_op = ALU_OR;
          default:    alu_op = ALU_AND;
        endcase
      end
      is_br: begin
        case (funct3)
          FUNC3_BEQ: begin
            alu_op = ALU_SUB;
            br_inv = 1'b0;
          end
          FUNC3_BNE: begin
            alu_op = ALU_SUB;
            br_inv = 1'b1;
          end
          FUNC3_BLT: begin
            alu_op = ALU_SLT;
            br_inv = 1'b1;
          end
          FUNC3_BGE: begin
            alu_op = ALU_SLT;
            br_inv = 1'b0;
          end
          FUNC3_BLTU: begin
            alu_op = ALU_SLTU;
            br_inv = 1'b1;
          end
          FUNC3_BGEU: begin
            alu_op = ALU_SLTU;
            br_inv = 1'b0;
          end
          default: begin
            alu_op = ALU_ADD;
            br_inv = 1'b0;
          end
        endcase
      end
      default: begin
        alu_op = ALU_ADD;
        br_inv = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/core_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB
// with imem/dmem req/ack handshakes and retired-instruction count.
module core_ctrl_fsm
  import core_ctrl_fsm_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [6:0]       inst_opcode,
  input  logic [2:0]       inst_funct3,
  input  logic [6:0]       inst_funct7,
  input  logic             alu_rd_equals_zero,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             ir_wren,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             mdr_wren,
  output logic             pc_wren,
  output logic             sel_next_pc,
  output logic             reg_file_wen,
  output logic             wb_sel,
  output logic [3:0]       alu_op,
  output logic             alu_op_a_sel,
  output logic             alu_op_b_sel,
  output logic             illegal_inst,
  output logic [CNT_W-1:0] instret
);

  state_t           state_q;
  state_t           state_d;
  cls_t             cls_q;
  cls_t             dec_cls;
  logic [2:0]       f3_q;
  logic [6:0]       f7_q;
  logic             ill_q;
  logic [CNT_W-1:0] instret_q;
  logic [3:0]       dec_op;
  logic             br_inv;
  logic             taken;
  logic             retire;
  logic             alu_hold;
  logic             use_rs2;

  assign dec_cls  = classify(inst_opcode, inst_funct3);
  assign taken    = alu_rd_equals_zero ^ br_inv;
  assign alu_hold = (state_q == ST_EXEC) ||
                    (state_q == ST_MEM) ||
                    (state_q == ST_WB);
  assign use_rs2  = (cls_q == CLS_OP) ||
                    (cls_q == CLS_BRANCH);

  ctrl_alu_dec u_alu_dec (
    .cls    (cls_q),
    .funct3 (f3_q),
    .funct7 (f7_q),
    .alu_op (dec_op),
    .br_inv (br_inv)
  );

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  // Latch class and funct fields once, in DECODE.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cls_q <= CLS_NONE;
      f3_q  <= 3'd0;
      f7_q  <= 7'd0;
    end else if (state_q == ST_DECODE) begin
      cls_q <= dec_cls;
      f3_q  <= inst_funct3;
      f7_q  <= inst_funct7;
    end
  end

  // Sticky illegal flag, set on entry to TRAP.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      ill_q <= 1'b0;
    else if (state_d == ST_TRAP)
      ill_q <= 1'b1;
  end

  // Free-running retired-instruction counter.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      instret_q <= '0;
    else
      instret_q <= instret_q + {{(CNT_W-1){1'b0}}, retire};
  end

  assign instret      = instret_q;
  assign illegal_inst = ill_q;

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack)
          state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (dec_cls == CLS_NONE)
          state_d = ST_TRAP;
        else
          state_d = ST_EXEC;
      end
      ST_EXEC: begin
        case (cls_q)
          CLS_BRANCH: state_d = ST_FETCH;
          CLS_LOAD,
          CLS_STORE:  state_d = ST_MEM;
          CLS_OP,
          CLS_OPIMM:  state_d = ST_WB;
          default:    state_d = ST_TRAP;
        endcase
      end
      ST_MEM: begin
        if (dmem_ack)
          state_d = (cls_q == CLS_LOAD)
                    ? ST_WB : ST_FETCH;
      end
      ST_WB:     state_d = ST_FETCH;
      ST_TRAP:   state_d = ST_TRAP;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath controls from state, latched class and acks.
  always_comb begin
    imem_req     = 1'b0;
    ir_wren      = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    mdr_wren     = 1'b0;
    pc_wren      = 1'b0;
    sel_next_pc  = CTL_PC_PLUS4;
    reg_file_wen = 1'b0;
    wb_sel       = CTL_WB_ALU;
    alu_op       = ALU_ADD;
    alu_op_a_sel = CTL_ALU_A_RS1;
    alu_op_b_sel = CTL_ALU_B_RS2;
    retire       = 1'b0;
    if (alu_hold) begin
      alu_op       = dec_op;
      alu_op_b_sel = use_rs2 ? CTL_ALU_B_RS2
                             : CTL_ALU_B_IMM;
    end
    unique case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        ir_wren  = imem_ack;
      end
      ST_EXEC: begin
        if (cls_q == CLS_BRANCH) begin
          pc_wren     = 1'b1;
          sel_next_pc = taken ? CTL_PC_IMM
                              : CTL_PC_PLUS4;
          retire      = 1'b1;
        end
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == CLS_STORE);
        if (cls_q == CLS_LOAD) begin
          mdr_wren = dmem_ack;
        end else begin
          pc_wren  = dmem_ack;
          retire   = dmem_ack;
        end
      end
      ST_WB: begin
        reg_file_wen = 1'b1;
        wb_sel       = (cls_q == CLS_LOAD)
                       ? CTL_WB_MEM : CTL_WB_ALU;
        pc_wren      = 1'b1;
        retire       = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// Directed bench for core_ctrl_fsm: table of per-instruction
// vectors plus hand sequences for reset, trap and wrap.
module tb_core_ctrl_fsm;
  import core_ctrl_fsm_pkg::*;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [6:0]  inst_opcode = '0;
  logic [2:0]  inst_funct3 = '0;
  logic [6:0]  inst_funct7 = '0;
  logic        alu_rd_equals_zero = 1'b0;
  logic        imem_req;
  logic        imem_ack = 1'b0;
  logic        ir_wren;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack = 1'b0;
  logic        mdr_wren;
  logic        pc_wren;
  logic        sel_next_pc;
  logic        reg_file_wen;
  logic        wb_sel;
  logic [3:0]  alu_op;
  logic        alu_op_a_sel;
  logic        alu_op_b_sel;
  logic        illegal_inst;
  logic [31:0] instret;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_instret = '0;

  core_ctrl_fsm #(.CNT_W(32)) dut (
    .clk                (clk),
    .nrst               (nrst),
    .inst_opcode        (inst_opcode),
    .inst_funct3        (inst_funct3),
    .inst_funct7        (inst_funct7),
    .alu_rd_equals_zero (alu_rd_equals_zero),
    .imem_req           (imem_req),
    .imem_ack           (imem_ack),
    .ir_wren            (ir_wren),
    .dmem_req           (dmem_req),
    .dmem_we            (dmem_we),
    .dmem_ack           (dmem_ack),
    .mdr_wren           (mdr_wren),
    .pc_wren            (pc_wren),
    .sel_next_pc        (sel_next_pc),
    .reg_file_wen       (reg_file_wen),
    .wb_sel             (wb_sel),
    .alu_op             (alu_op),
    .alu_op_a_sel       (alu_op_a_sel),
    .alu_op_b_sel       (alu_op_b_sel),
    .illegal_inst       (illegal_inst),
    .instret            (instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       zero;
    int         idly;
    int         ddly;
    logic [3:0] alu;
    logic       bsel;
    logic       snp;
    int         cyc;
    int         rf;
    logic       wbs;
    int         mdr;
    int         dreq;
    logic       we;
  } vec_t;

  vec_t vt[20];

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Assert reset, check reset outputs, release and see FETCH.
  task automatic do_reset();
    nrst        = 1'b0;
    imem_ack    = 1'b0;
    dmem_ack    = 1'b0;
    exp_instret = '0;
    #1;
    check("rst_instret", instret, 32'd0);
    check("rst_illegal", {31'd0, illegal_inst}, 32'd0);
    check("rst_reqs", {30'd0, imem_req, dmem_req}, 32'd0);
    check("rst_strobes",
          {26'd0, pc_wren, reg_file_wen, ir_wren,
           mdr_wren, sel_next_pc, wb_sel}, 32'd0);
    check("rst_alu_op", {28'd0, alu_op}, {28'd0, ALU_ADD});
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    #1;
    check("idle_after_rel", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    check("fetch_after_rel", {31'd0, imem_req}, 32'd1);
  endtask

  // Run one instruction from a FETCH negedge until it retires.
  task automatic run_vec(input int id, input vec_t v);
    int   cyc   = 0;
    int   iseen = 0;
    int   dseen = 0;
    int   rf    = 0;
    int   mdr   = 0;
    int   ir    = 0;
    int   dreq  = 0;
    logic we    = 1'b0;
    logic wbs   = 1'b0;
    logic done  = 1'b0;
    logic [3:0] op  = '0;
    logic       as  = 1'b0;
    logic       bs  = 1'b0;
    logic       snp = 1'b0;
    inst_opcode        = v.op;
    inst_funct3        = v.f3;
    inst_funct7        = v.f7;
    alu_rd_equals_zero = v.zero;
    while (!done && cyc < 40) begin
      imem_ack = imem_req && (iseen >= v.idly);
      dmem_ack = dmem_req && (dseen >= v.ddly);
      #1;
      if (imem_req) iseen++;
      if (dmem_req) begin
        dseen++;
        dreq++;
        we = dmem_we;
      end
      if (ir_wren) ir++;
      if (mdr_wren) mdr++;
      if (reg_file_wen) begin
        rf++;
        wbs = wb_sel;
      end
      if (pc_wren) begin
        done = 1'b1;
        op   = alu_op;
        as   = alu_op_a_sel;
        bs   = alu_op_b_sel;
        snp  = sel_next_pc;
      end
      cyc++;
      @(negedge clk);
    end
    exp_instret = exp_instret + 32'd1;
    check($sformatf("v%0d_done", id), {31'd0, done}, 32'd1);
    check($sformatf("v%0d_cycles", id), cyc, v.cyc);
    check($sformatf("v%0d_alu_op", id), {28'd0, op}, {28'd0, v.alu});
    check($sformatf("v%0d_a_sel", id), {31'd0, as}, 32'd0);
    check($sformatf("v%0d_b_sel", id), {31'd0, bs}, {31'd0, v.bsel});
    check($sformatf("v%0d_next_pc", id), {31'd0, snp}, {31'd0, v.snp});
    check($sformatf("v%0d_ir_wren", id), ir, 1);
    check($sformatf("v%0d_rf_wen", id), rf, v.rf);
    check($sformatf("v%0d_wb_sel", id), {31'd0, wbs}, {31'd0, v.wbs});
    check($sformatf("v%0d_mdr", id), mdr, v.mdr);
    check($sformatf("v%0d_dreq", id), dreq, v.dreq);
    check($sformatf("v%0d_dmem_we", id), {31'd0, we}, {31'd0, v.we});
    check($sformatf("v%0d_instret", id), instret, exp_instret);
  endtask

  initial begin
    //       op             f3    f7     z  id dd alu       b  s  cy rf w  m  dr we
    vt[0]  = '{OPCODE_OP_IMM, 3'd0, 7'h00, 0, 0, 0, ALU_ADD,  1, 0, 4, 1, 0, 0, 0, 0};
    vt[1]  = '{OPCODE_OP,     3'd0, 7'h00, 0, 0, 0, ALU_ADD,  0, 0, 4, 1, 0, 0, 0, 0};
    vt[2]  = '{OPCODE_OP,     3'd0, 7'h20, 0, 0, 0, ALU_SUB,  0, 0, 4, 1, 0, 0, 0, 0};
    vt[3]  = '{OPCODE_OP,     3'd5, 7'h20, 0, 0, 0, ALU_SRA,  0, 0, 4, 1, 0, 0, 0, 0};
    vt[4]  = '{OPCODE_OP_IMM, 3'd0, 7'h60, 0, 0, 0, ALU_ADD,  1, 0, 4, 1, 0, 0, 0, 0};
    vt[5]  = '{OPCODE_OP_IMM, 3'd5, 7'h20, 0, 0, 0, ALU_SRA,  1, 0, 4, 1, 0, 0, 0, 0};
    vt[6]  = '{OPCODE_OP_IMM, 3'd2, 7'h00, 0, 0, 0, ALU_SLT,  1, 0, 4, 1, 0, 0, 0, 0};
    vt[7]  = '{OPCODE_OP,     3'd3, 7'h00, 0, 0, 0, ALU_SLTU, 0, 0, 4, 1, 0, 0, 0, 0};
    vt[8]  = '{OPCODE_OP,     3'd7, 7'h00, 0, 2, 0, ALU_AND,  0, 0, 6, 1, 0, 0, 0, 0};
    vt[9]  = '{OPCODE_LOAD,   3'd2, 7'h00, 0, 0, 3, ALU_ADD,  1, 0, 8, 1, 1, 1, 4, 0};
    vt[10] = '{OPCODE_LOAD,   3'd2, 7'h00, 0, 0, 0, ALU_ADD,  1, 0, 5, 1, 1, 1, 1, 0};
    vt[11] = '{OPCODE_STORE,  3'd2, 7'h00, 0, 0, 0, ALU_ADD,  1, 0, 4, 0, 0, 0, 1, 1};
    vt[12] = '{OPCODE_STORE,  3'd2, 7'h00, 0, 0, 2, ALU_ADD,  1, 0, 6, 0, 0, 0, 3, 1};
    vt[13] = '{OPCODE_BRANCH, 3'd0, 7'h00, 1, 0, 0, ALU_SUB,  0, 1, 3, 0, 0, 0, 0, 0};
    vt[14] = '{OPCODE_BRANCH, 3'd1, 7'h00, 1, 0, 0, ALU_SUB,  0, 0, 3, 0, 0, 0, 0, 0};
    vt[15] = '{OPCODE_BRANCH, 3'd4, 7'h00, 0, 0, 0, ALU_SLT,  0, 1, 3, 0, 0, 0, 0, 0};
    vt[16] = '{OPCODE_BRANCH, 3'd7, 7'h00, 0, 0, 0, ALU_SLTU, 0, 0, 3, 0, 0, 0, 0, 0};
    vt[17] = '{OPCODE_BRANCH, 3'd6, 7'h00, 1, 0, 0, ALU_SLTU, 0, 0, 3, 0, 0, 0, 0, 0};
    vt[18] = '{OPCODE_OP_IMM, 3'd4, 7'h20, 0, 0, 0, ALU_XOR,  1, 0, 4, 1, 0, 0, 0, 0};
    vt[19] = '{OPCODE_OP,     3'd5, 7'h00, 0, 0, 0, ALU_SRL,  0, 0, 4, 1, 0, 0, 0, 0};

    do_reset();

    for (int i = 0; i < 20; i++)
      run_vec(i, vt[i]);

    // Counter wrap: preload all-ones while stalled in FETCH.
    imem_ack = 1'b0;
    force dut.instret_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.instret_q;
    #1;
    check("wrap_preload", instret, 32'hFFFF_FFFF);
    exp_instret = 32'hFFFF_FFFF;
    run_vec(100, vt[1]);
    check("wrap_zero", instret, 32'd0);

    // Reset in MEM of a stalled store.
    inst_opcode = OPCODE_STORE;
    inst_funct3 = 3'd2;
    imem_ack    = 1'b1;
    dmem_ack    = 1'b0;
    for (int k = 0; k < 10 && !dmem_req; k++)
      @(negedge clk);
    check("st_mem_reached", {31'd0, dmem_req}, 32'd1);
    #2;
    nrst = 1'b0;
    #1;
    check("st_rst_dreq_drop", {31'd0, dmem_req}, 32'd0);
    do_reset();

    // Unsupported opcode and reserved branch funct3 both trap.
    for (int t = 0; t < 2; t++) begin
      inst_opcode = (t == 0) ? 7'b1111111 : OPCODE_BRANCH;
      inst_funct3 = (t == 0) ? 3'd0 : 3'd2;
      imem_ack    = 1'b1;
      @(negedge clk);
      check($sformatf("t%0d_decode_ill", t),
            {31'd0, illegal_inst}, 32'd0);
      imem_ack = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        #1;
        check($sformatf("t%0d_ill_%0d", t, k),
              {31'd0, illegal_inst}, 32'd1);
        check($sformatf("t%0d_quiet_%0d", t, k),
              {26'd0, imem_req, dmem_req, pc_wren,
               reg_file_wen, ir_wren, mdr_wren}, 32'd0);
        @(negedge clk);
      end
      check($sformatf("t%0d_instret", t), instret, exp_instret);
      do_reset();
    end

    // Normal operation resumes after the trap is cleared.
    run_vec(200, vt[0]);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/core_ctrl_fsm.md
# core_ctrl_fsm

Multi-cycle control sequencer for the single-issue RV32I datapath. It walks each instruction through FETCH/DECODE/EXEC/MEM/WB, and drives all datapath control inputs: PC write and next-PC select, register-file write, ALU op and operand selects, and write-back select. It also runs req/ack handshakes to the instruction and data memories, flags unsupported opcodes, and counts retired instructions.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- nrst  in  1  reset; one clock; asynchronous, active-low
- inst_opcode  in  7  from instruction decoder (valid from DECODE onward)
- inst_funct3  in  3  from decoder
- inst_funct7  in  7  from decoder
- alu_rd_equals_zero  in  1  ALU result == 0
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  fetch data valid, sampled only while imem_req=1
- ir_wren  out  1  load instruction register
- dmem_req  out  1  data access request
- dmem_we  out  1  1=store, 0=load; qualified by dmem_req
- dmem_ack  in  1  data access complete, sampled only while dmem_req=1
- mdr_wren  out  1  latch load data
- pc_wren  out  1  PC update strobe
- sel_next_pc  out  1  0=PC+4, 1=PC+imm
- reg_file_wen  out  1  register write strobe
- wb_sel  out  1  0=ALU result, 1=load data
- alu_op  out  4  ALU operation, shared ALU_* encoding
- alu_op_a_sel  out  1  0=rs1, 1=PC
- alu_op_b_sel  out  1  0=rs2, 1=imm
- illegal_inst  out  1  sticky, unsupported opcode seen
- instret  out  CNT_W  retired-instruction count

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- IDLE: entered during reset; leaves to FETCH on the first clock edge after nrst rises.
- FETCH:
  - imem_req=1.
  - On an edge with imem_ack=1: ir_wren=1 (combinational, same cycle), then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: classify inst_opcode.
  - OPCODE_OP, OP_IMM, LOAD, STORE, BRANCH go to EXEC.
  - Any other opcode goes to TRAP.
- EXEC, operand selects and alu_op per class:
  - OP: a=rs1, b=rs2; op from funct3/funct7 (funct7[5] selects SUB/SRA).
  - OP_IMM: a=rs1, b=imm; funct7[5] is honoured only for funct3=SRx.
  - LOAD/STORE: a=rs1, b=imm; ALU_ADD.
  - BRANCH: a=rs1, b=rs2.
    - BEQ/BNE use ALU_SUB: taken = zero (BEQ) or !zero (BNE).
    - BLT/BGE use ALU_SLT; BLTU/BGEU use ALU_SLTU: taken = !zero (BLT/BLTU) or zero (BGE/BGEU).
    - In EXEC: pc_wren=1, sel_next_pc=taken, next state FETCH, instret increments.
    - funct3 010/011 is treated as illegal and goes to TRAP.
- EXEC next state: LOAD/STORE go to MEM; OP/OP_IMM go to WB.
- MEM:
  - dmem_req=1, dmem_we=(STORE). ALU selects are held at their EXEC values so the address stays stable.
  - On dmem_ack:
    - LOAD: mdr_wren=1, then go to WB.
    - STORE: pc_wren=1, sel_next_pc=0, instret++, then go to FETCH.
- WB:
  - reg_file_wen=1, wb_sel=(LOAD), pc_wren=1, sel_next_pc=0, instret++.
  - ALU selects are held; next state FETCH.
- TRAP:
  - illegal_inst=1; all strobes and requests are 0.
  - Stays in TRAP until reset.
- Strobes not named for a state are 0 in that state.
- instret is a free-running counter that wraps from all-ones to 0.

## Timing
- Reset (async, takes effect immediately on nrst falling):
  - state=IDLE, instret=0, illegal_inst=0.
  - All other outputs 0; alu_op=ALU_ADD.
- Outputs are Moore-decoded from state and the latched opcode class, except ir_wren/mdr_wren and the MEM-state pc_wren, which also depend on ack.
- An ack may arrive in the same cycle that req rises. With acks tied high:
  - OP/OP_IMM: 4 cycles (FETCH, DECODE, EXEC, WB).
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH: 3 cycles.
- Each wait cycle on imem_ack or dmem_ack adds exactly one cycle. A req stays high, with constant dmem_we, until its ack.
- An ack while the matching req=0 is ignored.
- Reset mid-handshake drops req in the same cycle. The memory side must tolerate an abandoned request.
- Opcode class is latched in DECODE. Changes on inst_* after DECODE have no effect on sequencing.

## Structure
- Shared package/header (opcode.vh) holds:
  - OPCODE_*, FUNC3_* and ALU_* encodings.
  - CTL_PC_*, CTL_ALU_A_*, CTL_ALU_B_* select constants.
  - CTL_WB_ALU/CTL_WB_MEM constants.
  - The state encoding.
- One sub-module, ctrl_alu_dec: combinational map of (class, funct3, funct7) to alu_op plus the branch-taken polarity bit.

## Test plan
- addi x1,x0,5, acks tied high:
  - IDLE, FETCH, DECODE, EXEC, WB.
  - reg_file_wen=1 only in WB, alu_op=ALU_ADD, alu_op_b_sel=1.
  - instret goes 0 to 1.
- lw with dmem_ack delayed 3 cycles:
  - dmem_req high for 4 cycles with dmem_we=0.
  - mdr_wren pulses once; WB has wb_sel=1.
  - Total 8 cycles.
- beq with zero=1, then bne with zero=1:
  - First: sel_next_pc=1 with pc_wren in EXEC.
  - Second: sel_next_pc=0.
  - Each takes 3 cycles.
- Opcode 7'b1111111:
  - TRAP after DECODE; illegal_inst stays 1.
  - No pc_wren or reg_file_wen; cleared only by nrst.
- Drop nrst during MEM of a store:
  - dmem_req falls immediately; state IDLE; instret=0.
  - FETCH resumes one edge after release.
- Preload instret to all-ones (force), retire one add: instret wraps to 0.
